parallel_processor: RTL and testbench

// - Four independent 8-bit compute lanes (CPU0..CPU3) sharing one single-port 8-bit memory.
// - Each lane takes an opcode on START and either computes an ALU result or performs a LOAD/STORE.
// - LOAD/STORE go to the shared memory through a request/acknowledge arbiter.
// - Top-level compute block, driven per lane by the processor testbench driver.

---
 rtl/parallel_processor_if.sv | 27 ++
 rtl/parallel_processor.sv | 218 +++++++++++++++++++++
 tb/tb_parallel_processor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parallel_processor_if.sv
// Lane bus for parallel_processor: per-lane operands, start/done handshake,
// memory request/acknowledge and the shared memory read byte.
interface parallel_processor_if;
    logic [3:0][7:0]  A;
    logic [3:0][7:0]  B;
    logic [3:0][3:0]  OPCODE;
    logic [3:0]       START;
    logic [3:0][7:0]  ADDRESS;
    logic [3:0][7:0]  data_in;
    logic [3:0][15:0] RESULT;
    logic [3:0]       DONE;
    logic [3:0]       BUSY;
    logic [3:0]       REQ;
    logic [3:0]       ACK;
    logic [3:0]       RW;
    logic [7:0]       data_out;

    modport master (
        output A, B, OPCODE, START, ADDRESS, data_in,
        input  RESULT, DONE, BUSY, REQ, ACK, RW, data_out
    );

    modport slave (
        input  A, B, OPCODE, START, ADDRESS, data_in,
        output RESULT, DONE, BUSY, REQ, ACK, RW, data_out
    );
endinterface

// File: rtl/parallel_processor.sv
// parallel_processor: four independent 8-bit ALU lanes sharing one
// single-port 256x8 memory through a registered request/acknowledge arbiter.
// Build option: define ROUND_ROBIN_EN for round-robin arbitration (the lane
// after the last granted one has highest priority); otherwise fixed priority
// with lane 0 highest.
module parallel_processor #(
    parameter int unsigned NUM_CPU   = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                 clock,
    input  logic                 RESETn,
    parallel_processor_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT
    } lane_state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_NOT   = 4'd6,
        OP_SHL   = 4'd7,
        OP_LOAD  = 4'd8,
        OP_STORE = 4'd9
    } opcode_e;

    lane_state_e       state   [NUM_CPU];
    logic [7:0]        a_r     [NUM_CPU];
    logic [7:0]        b_r     [NUM_CPU];
    logic [3:0]        op_r    [NUM_CPU];
    logic [ADDR_W-1:0] addr_r  [NUM_CPU];
    logic [7:0]        din_r   [NUM_CPU];

    logic [7:0]        mem     [MEM_DEPTH];

    logic              acc_valid;
    logic              acc_store;
    logic [ADDR_W-1:0] acc_addr;
    logic [7:0]        acc_wdata;
    logic [7:0]        rd_data;

    logic [NUM_CPU-1:0] grant_vec;
    logic [1:0]         grant_idx;
    logic               grant_valid;
`ifdef ROUND_ROBIN_EN
    logic [1:0]         rr_ptr;
    logic [1:0]         cand;
`endif

    function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
        logic [15:0] r;
        logic [8:0]  sum9;
        r    = '0;
        sum9 = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  r = {7'b0, sum9};
            OP_SUB:  r = {8'h00, a} - {8'h00, b};
            OP_MUL:  r = {8'h00, a} * {8'h00, b};
            OP_AND:  r = {8'h00, a & b};
            OP_OR:   r = {8'h00, a | b};
            OP_XOR:  r = {8'h00, a ^ b};
            OP_NOT:  r = {8'h00, ~a};
            OP_SHL:  r = {8'h00, a} << b[2:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Pick the next lane to grant from the current requests.
    always_comb begin
        grant_vec   = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
`ifdef ROUND_ROBIN_EN
        cand = '0;
        for (int unsigned k = 0; k < NUM_CPU; k++) begin
            cand = rr_ptr + k[1:0];
            if (!grant_valid && bus.REQ[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
`else
        for (int unsigned k = 0; k < NUM_CPU; k++) begin
            if (!grant_valid && bus.REQ[k]) begin
                grant_valid = 1'b1;
                grant_idx   = k[1:0];
            end
        end
`endif
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Registered one-cycle ACK; no new grant while an ACK is still high.
    always_ff @(posedge clock) begin
        if (!RESETn) begin
            bus.ACK <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr  <= '0;
`endif
        end else if (|bus.ACK) begin
            bus.ACK <= '0;
        end else begin
            bus.ACK <= grant_vec;
`ifdef ROUND_ROBIN_EN
            if (grant_valid) begin
                rr_ptr <= grant_idx + 2'd1;
            end
`endif
        end
    end

    // Route the acknowledged lane's access onto the single memory port.
    always_comb begin
        acc_valid = 1'b0;
        acc_store = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        for (int unsigned k = 0; k < NUM_CPU; k++) begin
            if (bus.ACK[k]) begin
                acc_valid = 1'b1;
                acc_store = (op_r[k] == OP_STORE);
                acc_addr  = addr_r[k];
                acc_wdata = din_r[k];
            end
        end
        rd_data = mem[acc_addr];
    end

    // Shared memory: cleared on reset, one access per cycle on ACK.
    always_ff @(posedge clock) begin
        if (!RESETn) begin
            for (int unsigned j = 0; j < MEM_DEPTH; j++) begin
                mem[j] <= '0;
            end
            bus.data_out <= '0;
        end else if (acc_valid) begin
            if (acc_store) begin
                mem[acc_addr] <= acc_wdata;
            end else begin
                bus.data_out <= rd_data;
            end
        end
    end

    // Per-lane FSM: IDLE -> EXEC -> IDLE for ALU ops, IDLE -> WAIT -> IDLE for memory ops.
    always_ff @(posedge clock) begin
        if (!RESETn) begin
            for (int unsigned i = 0; i < NUM_CPU; i++) begin
                state[i]  <= S_IDLE;
                a_r[i]    <= '0;
                b_r[i]    <= '0;
                op_r[i]   <= '0;
                addr_r[i] <= '0;
                din_r[i]  <= '0;
            end
            bus.RESULT <= '0;
            bus.DONE   <= '0;
            bus.BUSY   <= '0;
            bus.REQ    <= '0;
            bus.RW     <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CPU; i++) begin
                bus.DONE[i] <= 1'b0;
                case (state[i])
                    S_IDLE: begin
                        if (bus.START[i]) begin
                            a_r[i]      <= bus.A[i];
                            b_r[i]      <= bus.B[i];
                            op_r[i]     <= bus.OPCODE[i];
                            addr_r[i]   <= bus.ADDRESS[i];
                            din_r[i]    <= bus.data_in[i];
                            bus.BUSY[i] <= 1'b1;
                            if (bus.OPCODE[i] == OP_LOAD || bus.OPCODE[i] == OP_STORE) begin
                                state[i]    <= S_WAIT;
                                bus.REQ[i]  <= 1'b1;
                                bus.RW[i]   <= (bus.OPCODE[i] == OP_STORE);
                            end else begin
                                state[i] <= S_EXEC;
                            end
                        end
                    end
                    S_EXEC: begin
                        bus.RESULT[i] <= alu(a_r[i], b_r[i], op_r[i]);
                        bus.DONE[i]   <= 1'b1;
                        bus.BUSY[i]   <= 1'b0;
                        state[i]      <= S_IDLE;
                    end
                    S_WAIT: begin
                        if (bus.ACK[i]) begin
                            if (op_r[i] != OP_STORE) begin
                                bus.RESULT[i] <= {8'h00, rd_data};
                            end
                            bus.REQ[i]  <= 1'b0;
                            bus.RW[i]   <= 1'b0;
                            bus.DONE[i] <= 1'b1;
                            bus.BUSY[i] <= 1'b0;
                            state[i]    <= S_IDLE;
                        end
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parallel_processor.sv
// Directed self-checking bench for parallel_processor. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_parallel_processor;

    logic clock;
    logic RESETn;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] exp_ack4 [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                 4'b0100, 4'b0000, 4'b1000, 4'b0000};
`ifdef ROUND_ROBIN_EN
    logic [3:0] exp_ack3 [6] = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    logic [7:0] exp_dout3 = 8'h11;
`else
    logic [3:0] exp_ack3 [6] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
    logic [7:0] exp_dout3 = 8'h44;
`endif

    parallel_processor_if bus();

    parallel_processor dut (
        .clock  (clock),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lane_cfg(input int unsigned i, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] addr, input logic [7:0] din);
        bus.OPCODE[i]  = op;
        bus.A[i]       = a;
        bus.B[i]       = b;
        bus.ADDRESS[i] = addr;
        bus.data_in[i] = din;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, 64'(bus.RESULT), 64'h0);
        chk({tag, "_done"}, 64'(bus.DONE), 64'h0);
        chk({tag, "_busy"}, 64'(bus.BUSY), 64'h0);
        chk({tag, "_req"}, 64'(bus.REQ), 64'h0);
        chk({tag, "_ack"}, 64'(bus.ACK), 64'h0);
        chk({tag, "_rw"}, 64'(bus.RW), 64'h0);
        chk({tag, "_dout"}, 64'(bus.data_out), 64'h0);
    endtask

    initial begin
        RESETn      = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.OPCODE  = '0;
        bus.START   = '0;
        bus.ADDRESS = '0;
        bus.data_in = '0;

        // Reset and idle
        step();
        step();
        chk_all_zero("reset");
        RESETn = 1'b1;
        step();
        step();
        step();
        chk_all_zero("idle");

        // Lane0 ADD with carry, lane1 MUL in parallel
        lane_cfg(0, 4'd0, 8'hFF, 8'h01, 8'h00, 8'h00);
        lane_cfg(1, 4'd2, 8'hFF, 8'hFF, 8'h00, 8'h00);
        bus.START = 4'b0011;
        step();
        chk("alu_busy", 64'(bus.BUSY), 64'h3);
        chk("alu_done_early", 64'(bus.DONE), 64'h0);
        bus.START = 4'b0000;
        step();
        chk("alu_done", 64'(bus.DONE), 64'h3);
        chk("add_result", 64'(bus.RESULT[0]), 64'h0100);
        chk("mul_result", 64'(bus.RESULT[1]), 64'hFE01);
        chk("alu_busy_clear", 64'(bus.BUSY), 64'h0);
        step();
        chk("done_pulse", 64'(bus.DONE), 64'h0);
        chk("add_held", 64'(bus.RESULT[0]), 64'h0100);

        // Lane2 SUB wraparound, then undefined opcode
        lane_cfg(2, 4'd1, 8'h03, 8'h05, 8'h00, 8'h00);
        bus.START = 4'b0100;
        step();
        bus.START = 4'b0000;
        step();
        chk("sub_result", 64'(bus.RESULT[2]), 64'hFFFE);
        chk("sub_done", 64'(bus.DONE), 64'h4);
        lane_cfg(2, 4'd12, 8'h07, 8'h09, 8'h00, 8'h00);
        bus.START = 4'b0100;
        step();
        bus.START = 4'b0000;
        step();
        chk("op12_result", 64'(bus.RESULT[2]), 64'h0);
        chk("op12_done", 64'(bus.DONE), 64'h4);

        // START held while busy: second request ignored
        lane_cfg(3, 4'd0, 8'h01, 8'h02, 8'h00, 8'h00);
        bus.START = 4'b1000;
        step();
        lane_cfg(3, 4'd0, 8'h10, 8'h20, 8'h00, 8'h00);
        step();
        chk("busy_ign_result", 64'(bus.RESULT[3]), 64'h0003);
        chk("busy_ign_done", 64'(bus.DONE), 64'h8);
        bus.START = 4'b0000;
        step();
        chk("busy_ign_idle", 64'(bus.BUSY), 64'h0);
        chk("busy_ign_held", 64'(bus.RESULT[3]), 64'h0003);

        // Logic ops and shift on all lanes
        lane_cfg(0, 4'd3, 8'hF0, 8'h3C, 8'h00, 8'h00);
        lane_cfg(1, 4'd4, 8'hF0, 8'h3C, 8'h00, 8'h00);
        lane_cfg(2, 4'd5, 8'hF0, 8'h3C, 8'h00, 8'h00);
        lane_cfg(3, 4'd7, 8'h81, 8'h0F, 8'h00, 8'h00);
        bus.START = 4'b1111;
        step();
        bus.START = 4'b0000;
        step();
        chk("logic_results", 64'(bus.RESULT), 64'h4080_00CC_00FC_0030);
        chk("logic_done", 64'(bus.DONE), 64'hF);
        lane_cfg(0, 4'd6, 8'h3C, 8'h00, 8'h00, 8'h00);
        bus.START = 4'b0001;
        step();
        bus.START = 4'b0000;
        step();
        chk("not_result", 64'(bus.RESULT[0]), 64'h00C3);

        // Lane0 STORE, then lane3 LOAD of the same address
        lane_cfg(0, 4'd9, 8'h00, 8'h00, 8'h10, 8'hA5);
        bus.START = 4'b0001;
        step();
        chk("st_req", 64'(bus.REQ), 64'h1);
        chk("st_rw", 64'(bus.RW), 64'h1);
        chk("st_busy", 64'(bus.BUSY), 64'h1);
        chk("st_ack_early", 64'(bus.ACK), 64'h0);
        bus.START = 4'b0000;
        step();
        chk("st_ack", 64'(bus.ACK), 64'h1);
        chk("st_done_early", 64'(bus.DONE), 64'h0);
        step();
        chk("st_ack_pulse", 64'(bus.ACK), 64'h0);
        chk("st_req_clear", 64'(bus.REQ), 64'h0);
        chk("st_done", 64'(bus.DONE), 64'h1);
        chk("st_result_kept", 64'(bus.RESULT[0]), 64'h00C3);

        lane_cfg(3, 4'd8, 8'h00, 8'h00, 8'h10, 8'h00);
        bus.START = 4'b1000;
        step();
        chk("ld_req", 64'(bus.REQ), 64'h8);
        chk("ld_rw", 64'(bus.RW), 64'h0);
        bus.START = 4'b0000;
        step();
        chk("ld_ack", 64'(bus.ACK), 64'h8);
        step();
        chk("ld_done", 64'(bus.DONE), 64'h8);
        chk("ld_result", 64'(bus.RESULT[3]), 64'h00A5);
        chk("ld_dout", 64'(bus.data_out), 64'hA5);

        // Four simultaneous STOREs, grants spaced in lane order
        lane_cfg(0, 4'd9, 8'h00, 8'h00, 8'h20, 8'h11);
        lane_cfg(1, 4'd9, 8'h00, 8'h00, 8'h21, 8'h22);
        lane_cfg(2, 4'd9, 8'h00, 8'h00, 8'h22, 8'h33);
        lane_cfg(3, 4'd9, 8'h00, 8'h00, 8'h23, 8'h44);
        bus.START = 4'b1111;
        step();
        chk("st4_req", 64'(bus.REQ), 64'hF);
        bus.START = 4'b0000;
        for (int j = 0; j < 8; j++) begin
            step();
            chk($sformatf("st4_ack%0d", j), 64'(bus.ACK), 64'(exp_ack4[j]));
        end
        chk("st4_last_done", 64'(bus.DONE), 64'h8);
        chk("st4_idle", 64'(bus.BUSY), 64'h0);

        // Read the four values back in permuted order
        lane_cfg(0, 4'd8, 8'h00, 8'h00, 8'h23, 8'h00);
        lane_cfg(1, 4'd8, 8'h00, 8'h00, 8'h22, 8'h00);
        lane_cfg(2, 4'd8, 8'h00, 8'h00, 8'h21, 8'h00);
        lane_cfg(3, 4'd8, 8'h00, 8'h00, 8'h20, 8'h00);
        bus.START = 4'b1111;
        step();
        bus.START = 4'b0000;
        repeat (8) step();
        chk("ld4_results", 64'(bus.RESULT), 64'h0011_0022_0033_0044);
        chk("ld4_dout", 64'(bus.data_out), 64'h11);
        chk("ld4_idle", 64'(bus.BUSY), 64'h0);

        // Lane1 STORE moves the round-robin pointer, then three-way contention
        lane_cfg(1, 4'd9, 8'h00, 8'h00, 8'h40, 8'h5C);
        bus.START = 4'b0010;
        step();
        bus.START = 4'b0000;
        step();
        step();
        chk("rr_st_done", 64'(bus.DONE), 64'h2);
        lane_cfg(0, 4'd8, 8'h00, 8'h00, 8'h40, 8'h00);
        lane_cfg(1, 4'd8, 8'h00, 8'h00, 8'h20, 8'h00);
        lane_cfg(3, 4'd8, 8'h00, 8'h00, 8'h23, 8'h00);
        bus.START = 4'b1011;
        step();
        chk("ct_req", 64'(bus.REQ), 64'hB);
        bus.START = 4'b0000;
        for (int j = 0; j < 6; j++) begin
            step();
            chk($sformatf("ct_ack%0d", j), 64'(bus.ACK), 64'(exp_ack3[j]));
        end
        chk("ct_results", 64'(bus.RESULT), 64'h0044_0022_0011_005C);
        chk("ct_dout", 64'(bus.data_out), 64'(exp_dout3));

        // Reset while lane1 waits for memory
        lane_cfg(1, 4'd8, 8'h00, 8'h00, 8'h10, 8'h00);
        bus.START = 4'b0010;
        step();
        chk("rst_wait_req", 64'(bus.REQ), 64'h2);
        bus.START = 4'b0000;
        RESETn = 1'b0;
        step();
        chk_all_zero("midreset");
        RESETn = 1'b1;
        step();
        step();
        chk("post_rst_done", 64'(bus.DONE), 64'h0);
        chk("post_rst_req", 64'(bus.REQ), 64'h0);
        chk("post_rst_ack", 64'(bus.ACK), 64'h0);
        lane_cfg(2, 4'd8, 8'h00, 8'h00, 8'h10, 8'h00);
        bus.START = 4'b0100;
        step();
        bus.START = 4'b0000;
        step();
        step();
        chk("mem_clr_done", 64'(bus.DONE), 64'h4);
        chk("mem_clr_result", 64'(bus.RESULT[2]), 64'h0);
        chk("mem_clr_dout", 64'(bus.data_out), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
